// File: rtl/fp_pkg.sv
// Shared helpers for the fixed-point adder/subtractor family:
// width selection and two's complement saturation limits.
package fp_pkg;

  // Larger of two widths; used to size the common Q(n.m) result format.
  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Most positive value of a w-bit two's complement number (w <= 64).
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Most negative value of a w-bit two's complement number (w <= 64).
  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/fp_align.sv
// Combinational alignment of one Q(i.f) operand into the common Q(n.m)
// format: sign-extend to W bits, then shift left so the binary points line up.
module fp_align #(
  parameter int IN_W    = 16,
  parameter int IN_FRAC = 12,
  parameter int W       = 18,
  parameter int M       = 12
) (
  input  logic signed [IN_W-1:0] din,
  output logic signed [W-1:0]    dout
);

  // Zero when the operand already has the widest fraction.
  localparam int SH = M - IN_FRAC;

  logic signed [W-1:0] ext;

  // Size cast of a signed operand sign-extends; integer bits never exceed n,
  // so the shift cannot push significant bits out of the top.
  assign ext  = W'(din);
  assign dout = ext <<< SH;

endmodule

// File: rtl/fp_sub_pipe.sv
// Two-stage pipelined fixed-point subtractor C = A - B with valid/ready
// handshakes on both sides. Stage 1 holds the aligned operands, stage 2
// holds the difference and the overflow flag.
// Optional build macro FP_SUB_SAT_EN: clamp overflowing results to the
// Q(n.m) limits instead of wrapping (overflow is reported either way).
module fp_sub_pipe
  import fp_pkg::*;
#(
  parameter int  n1 = 4,
  parameter int  m1 = 12,
  parameter int  n2 = 6,
  parameter int  m2 = 10,
  localparam int n  = max_w(n1, n2),
  localparam int m  = max_w(m1, m2),
  localparam int W  = n + m
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [n1+m1-1:0] A,
  input  logic signed [n2+m2-1:0] B,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [W-1:0]    C,
  output logic                   overflow
);

`ifdef FP_SUB_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic signed [63:0]  SAT_MAX_L = sat_max(W);
  localparam logic signed [63:0]  SAT_MIN_L = sat_min(W);
  localparam logic signed [W-1:0] SAT_MAX   = SAT_MAX_L[W-1:0];
  localparam logic signed [W-1:0] SAT_MIN   = SAT_MIN_L[W-1:0];

  logic signed [W-1:0] a_al;
  logic signed [W-1:0] b_al;
  logic signed [W-1:0] a_p1;
  logic signed [W-1:0] b_p1;
  logic signed [W-1:0] diff;
  logic                vld_p1;
  logic                ovf;
  logic                advance;

  // On overflow the true result lies beyond the limit on a's side of zero.
  function automatic logic signed [W-1:0] saturate(
    input logic signed [W-1:0] raw,
    input logic                ovf_i,
    input logic                a_neg
  );
    if (SAT_EN && ovf_i)
      return a_neg ? SAT_MIN : SAT_MAX;
    return raw;
  endfunction

  fp_align #(
    .IN_W    (n1 + m1),
    .IN_FRAC (m1),
    .W       (W),
    .M       (m)
  ) u_align_a (
    .din  (A),
    .dout (a_al)
  );

  fp_align #(
    .IN_W    (n2 + m2),
    .IN_FRAC (m2),
    .W       (W),
    .M       (m)
  ) u_align_b (
    .din  (B),
    .dout (b_al)
  );

  // Stage 2 can take new data when empty or when its result leaves this cycle;
  // stage 1 can take new data when empty or when it moves into stage 2.
  assign advance  = !out_valid || out_ready;
  assign in_ready = !vld_p1 || advance;

  // Difference wraps modulo 2^W; overflow is the classic sign test.
  assign diff = a_p1 - b_p1;
  assign ovf  = (a_p1[W-1] != b_p1[W-1]) && (diff[W-1] != a_p1[W-1]);

  // ---- stage 1: aligned operands ----
  // Stage-1 occupancy; a bubble is loaded when in_valid is low.
  always_ff @(posedge clk) begin
    if (rst)
      vld_p1 <= 1'b0;
    else if (in_ready)
      vld_p1 <= in_valid;
  end

  // Operand capture on an input transfer.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      a_p1 <= a_al;
      b_p1 <= b_al;
    end
  end

  // ---- stage 2: result and overflow ----
  // Result register; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      C         <= '0;
      overflow  <= 1'b0;
    end else if (advance) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        C        <= saturate(diff, ovf, a_p1[W-1]);
        overflow <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_fp_sub_pipe.sv
// Self-checking bench for fp_sub_pipe: directed vectors, stall, reset and a
// random handshake run against a reference model on the default build and on
// an equal-fraction (m1 == m2) build.
module tb_fp_sub_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic [17:0] B1;

  logic        in_ready0, out_valid0, ovf0;
  logic [17:0] c0;
  logic        in_ready1, out_valid1, ovf1;
  logic [17:0] c1;

  int checks   = 0;
  int failures = 0;
  int n_acc0   = 0;
  int n_acc1   = 0;
  int n_out0   = 0;

  logic [18:0] q0[$];
  logic [18:0] q1[$];

  fp_sub_pipe u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .A         (A),
    .B         (B),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .C         (c0),
    .overflow  (ovf0)
  );

  fp_sub_pipe #(.n1(4), .m1(12), .n2(6), .m2(12)) u_dut_eq (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .A         (A),
    .B         (B1),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .C         (c1),
    .overflow  (ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operands scaled to units of 2^-12; exact difference, range-checked.
  function automatic logic [18:0] model(input longint a_s, input longint b_s);
    longint      d;
    logic        o;
    logic [17:0] c;
    d = a_s - b_s;
    o = (d > 64'sd131071) || (d < -64'sd131072);
    c = d[17:0];
`ifdef FP_SUB_SAT_EN
    if (o) c = (a_s < 0) ? 18'h20000 : 18'h1FFFF;
`endif
    return {o, c};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop on output transfer, push on input transfer.
  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (out_valid0 && out_ready) begin
        n_out0++;
        checks++;
        assert (q0.size() != 0) else begin
          failures++;
          $error("FAIL sb0_unexpected observed=result C=%h expected=no result", c0);
        end
        if (q0.size() != 0) begin
          logic [18:0] e;
          e = q0.pop_front();
          chk("sb0_c", {14'd0, c0}, {14'd0, e[17:0]});
          chk("sb0_ovf", {31'd0, ovf0}, {31'd0, e[18]});
        end
      end
      if (out_valid1 && out_ready) begin
        checks++;
        assert (q1.size() != 0) else begin
          failures++;
          $error("FAIL sb1_unexpected observed=result C=%h expected=no result", c1);
        end
        if (q1.size() != 0) begin
          logic [18:0] e;
          e = q1.pop_front();
          chk("sb1_c", {14'd0, c1}, {14'd0, e[17:0]});
          chk("sb1_ovf", {31'd0, ovf1}, {31'd0, e[18]});
        end
      end
      if (in_valid && in_ready0) begin
        n_acc0++;
        q0.push_back(model(longint'($signed(A)), longint'($signed(B)) * 4));
      end
      if (in_valid && in_ready1) begin
        n_acc1++;
        q1.push_back(model(longint'($signed(A)), longint'($signed(B1))));
      end
    end
  end

  task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [17:0] exp_c, input logic exp_o);
    in_valid = 1'b1;
    A = a;
    B = b;
    @(negedge clk);
    chk({tag, "_in_ready"}, {31'd0, in_ready0}, 32'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_vld_lat1"}, {31'd0, out_valid0}, 32'd0);
    tick();
    @(negedge clk);
    chk({tag, "_vld_lat2"}, {31'd0, out_valid0}, 32'd1);
    chk({tag, "_c"}, {14'd0, c0}, {14'd0, exp_c});
    chk({tag, "_ovf"}, {31'd0, ovf0}, {31'd0, exp_o});
    tick();
  endtask

  logic [15:0] va[8];
  logic [15:0] vb[8];
  logic [18:0] exp0;
  logic        acc;
  int          idx;
  int          base_out;
  int          base_acc;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A  = '0;
    B  = '0;
    B1 = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready0}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid0}, 32'd0);
    chk("rst_c", {14'd0, c0}, 32'd0);
    chk("rst_ovf", {31'd0, ovf0}, 32'd0);
    tick();

    directed("half", 16'h1000, 16'h0200, 18'h00800, 1'b0);
`ifdef FP_SUB_SAT_EN
    directed("neg_ovf", 16'h8000, 16'h7FFF, 18'h20000, 1'b1);
    directed("pos_ovf", 16'h7FFF, 16'h8000, 18'h1FFFF, 1'b1);
`else
    directed("neg_ovf", 16'h8000, 16'h7FFF, 18'h18004, 1'b1);
    directed("pos_ovf", 16'h7FFF, 16'h8000, 18'h27FFF, 1'b1);
`endif
    directed("zero", 16'h0000, 16'h0000, 18'h00000, 1'b0);

    // Back-to-back inputs against a stalled consumer.
    for (int i = 0; i < 8; i++) begin
      va[i] = 16'(i * 16'h0923 + 16'h0101);
      vb[i] = 16'(16'hF000 + i * 16'h0157);
    end
    exp0 = model(longint'($signed(va[0])), longint'($signed(vb[0])) * 4);
    base_out = n_out0;
    idx = 0;
    for (int cyc = 0; cyc < 200 && idx < 8; cyc++) begin
      A = va[idx];
      B = vb[idx];
      in_valid  = 1'b1;
      out_ready = (cyc >= 5);
      @(negedge clk);
      acc = in_ready0;
      if (cyc == 2) begin
        chk("stall_first_c", {14'd0, c0}, {14'd0, exp0[17:0]});
        chk("stall_in_ready_fall", {31'd0, in_ready0}, 32'd0);
      end
      if (cyc == 4) begin
        chk("stall_accepts", idx, 32'd2);
        chk("stall_hold_vld", {31'd0, out_valid0}, 32'd1);
        chk("stall_hold_c", {14'd0, c0}, {14'd0, exp0[17:0]});
        chk("stall_hold_ovf", {31'd0, ovf0}, {31'd0, exp0[18]});
      end
      tick();
      if (acc) idx++;
    end
    chk("stall_sent", idx, 32'd8);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 50 && q0.size() != 0; k++) tick();
    chk("stall_drained", q0.size(), 32'd0);
    chk("stall_results", n_out0 - base_out, 32'd8);

    // Reset with both stages occupied.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    A = 16'h1234;
    B = 16'h0042;
    tick();
    A = 16'h9ABC;
    B = 16'hFF00;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_out_valid", {31'd0, out_valid0}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", {31'd0, out_valid0}, 32'd0);
    chk("mid_rst_c", {14'd0, c0}, 32'd0);
    chk("mid_rst_ovf", {31'd0, ovf0}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready0}, 32'd1);
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rst_no_stale", {31'd0, out_valid0}, 32'd0);
      tick();
    end

    // Random handshakes on both builds.
    base_acc = n_acc0;
    for (int cyc = 0; cyc < 60000 && (n_acc0 - base_acc) < 10000; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      A  = 16'($urandom);
      B  = 16'($urandom);
      B1 = 18'($urandom);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("rand_count", n_acc0 - base_acc, 32'd10000);
    for (int k = 0; k < 50 && (q0.size() != 0 || q1.size() != 0); k++) tick();
    chk("rand_drained0", q0.size(), 32'd0);
    chk("rand_drained1", q1.size(), 32'd0);
    chk("rand_acc_match", n_acc1, n_acc0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_sub_pipe.md
FP_SUB_PIPE -- requirements
Module: fp_sub_pipe

Interface
REQ-001 SHALL have parameter n1, default 4, signed integer bit width of A (sign included).
REQ-002 SHALL have parameter m1, default 12, fractional bit width of A.
REQ-003 SHALL have parameter n2, default 6, signed integer bit width of B.
REQ-004 SHALL have parameter m2, default 10, fractional bit width of B.
REQ-005 SHALL derive n = max(n1,n2), m = max(m1,m2), W = n+m; these are not overridable.
REQ-006 SHALL have port clk  input  1  the single clock, rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port in_valid  input  1  A/B pair is valid.
REQ-009 SHALL have port in_ready  output  1  the block accepts the pair this cycle.
REQ-010 SHALL have port A  input  n1+m1  minuend, two's complement Q(n1.m1).
REQ-011 SHALL have port B  input  n2+m2  subtrahend, two's complement Q(n2.m2).
REQ-012 SHALL have port out_valid  output  1  C/overflow are valid.
REQ-013 SHALL have port out_ready  input  1  the consumer takes the result.
REQ-014 SHALL have port C  output  W  difference A-B, Q(n.m).
REQ-015 SHALL have port overflow  output  1  the true difference is outside the Q(n.m) range.

Function
REQ-016 SHALL transfer data on any port pair only in a cycle where valid and ready are both 1.
REQ-017 SHALL be a two-stage pipeline: stage 1 registers the aligned operands, stage 2 registers C/overflow; latency from input transfer to out_valid is exactly 2 cycles when not stalled.
REQ-018 SHALL align each operand by sign-extending it to W bits and shifting it left by (m - its own fractional width), padding zeros at the LSB.
REQ-019 SHALL compute C = a_aligned - b_aligned modulo 2^W.
REQ-020 SHALL set overflow = (sign(a) != sign(b)) & (sign(C_raw) != sign(a)), using the aligned operands and the unsaturated result.
REQ-021 SHALL drive in_ready = !s1_valid | advance, where advance = !out_valid | out_ready; stage 1 loads when it advances. Throughput is one result per cycle.
REQ-022 SHALL hold C, overflow and out_valid stable while out_valid=1 and out_ready=0, and SHALL never drop or duplicate a result under any stall pattern.
REQ-023 SHALL drop out_valid after the transfer if no new result advances in the same cycle; simultaneous output transfer and stage-1 advance SHALL update C with no bubble.
REQ-024 SHALL produce C exactly with no rounding; when m1 == m2 the shift amount is 0.

Reset
REQ-025 SHALL, on rst=1 at a clk edge, clear s1_valid and out_valid and set C=0 and overflow=0; in_ready reads 1 in the first cycle after reset.
REQ-026 SHALL discard in-flight data when rst is asserted mid-operation; no result appears after reset until a new input transfer.

Configuration
REQ-027 SHALL have macro FP_SUB_SAT_EN: when defined, an overflowing C SHALL saturate to 2^(W-1)-1 if sign(a)=0, or to -2^(W-1) if sign(a)=1; overflow is still reported.
REQ-028 SHALL, when FP_SUB_SAT_EN is undefined, output the wrapped C (REQ-019) with the overflow flag only.

Structure
REQ-029 SHALL have a shared package fp_pkg that holds the max() width function and the saturation-constant helpers, for reuse by the adder family.
REQ-030 SHALL have one sub-module, fp_align (parameters: in width, in fraction width, W, m), that performs the combinational sign-extend and shift and is instantiated once per operand.

Verification (default parameters, W=18)
REQ-031 SHALL verify: A=0x1000 (1.0), B=0x0200 (0.5) -> C=0x00800 (0.5), overflow=0, out_valid 2 cycles after the transfer.
REQ-032 SHALL verify: A=0x8000 (-8.0), B=0x7FFF (31.999) -> overflow=1; C=0x18004 without FP_SUB_SAT_EN, C=0x20000 with it.
REQ-033 SHALL verify: A=0x7FFF, B=0x8000 (-32.0) -> overflow=1; C=0x27FFF wrapped, or C=0x1FFFF saturated.
REQ-034 SHALL verify: 8 back-to-back inputs with out_ready=0 for 5 cycles, then 1 -> in_ready falls after 2 accepts, all 8 results arrive in order and are unchanged while stalled.
REQ-035 SHALL verify: rst pulsed while both stages are valid -> out_valid=0, C=0, overflow=0 on the next cycle, and no stale result appears afterwards.
REQ-036 SHALL verify: a random in_valid/out_ready test of 10k vectors against a reference model -> zero mismatches, including the case with parameters m1 == m2.
